// File: rtl/sevenseg_arb_pkg.sv
// Shared types for the seven-segment display arbiter: FSM states, owner codes
// and the display payload carried from a requester to the digit outputs.
package sevenseg_arb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DP_W    = 2;
  localparam int unsigned OWNER_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam logic [OWNER_W-1:0] OWNER_IDLE = 2'b00;
  localparam logic [OWNER_W-1:0] OWNER_A    = 2'b01;
  localparam logic [OWNER_W-1:0] OWNER_B    = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DP_W-1:0]   dp;
  } disp_t;

  // Owner code presented on the owner port for a given FSM state.
  function automatic logic [OWNER_W-1:0] owner_of(input state_e s);
    logic [OWNER_W-1:0] code;
    code = OWNER_IDLE;
    case (s)
      OWN_A:   code = OWNER_A;
      OWN_B:   code = OWNER_B;
      default: code = OWNER_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sevenseg_hold_timer.sv
// Minimum-ownership timer: cleared on every grant, counts owned cycles and
// saturates once the hold time has been served so expiry stays asserted.
module sevenseg_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q != CNT_MAX) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired_c = (count_q == CNT_MAX);

endmodule

// File: rtl/sevenseg_display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display between requesters
// A and B, with a minimum hold time and an idle pattern when nobody owns it.
module sevenseg_display_arbiter
  import sevenseg_arb_pkg::*;
#(
  parameter int unsigned       HOLD_CYCLES = 50000000,
  parameter logic [DATA_W-1:0] IDLE_VALUE  = 16'h0000,
  parameter logic [DP_W-1:0]   IDLE_DP     = 2'b00
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               req_a,
  input  logic [DATA_W-1:0]  data_a,
  input  logic [DP_W-1:0]    dp_a,
  output logic               gnt_a,
  input  logic               req_b,
  input  logic [DATA_W-1:0]  data_b,
  input  logic [DP_W-1:0]    dp_b,
  output logic               gnt_b,
  output logic [3:0]         digit0,
  output logic [3:0]         digit1,
  output logic [3:0]         digit2,
  output logic [3:0]         digit3,
  output logic [DP_W-1:0]    decplace,
  output logic [OWNER_W-1:0] owner
);

  state_e state_q;
  state_e state_nxt;
  logic   rr_b_q;     // 1: B wins the next simultaneous request from IDLE
  logic   rr_b_nxt;
  logic   grant_c;
  logic   expired_c;
  disp_t  disp_nxt;

  sevenseg_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk       (clk1),
    .rst_n     (rst_n),
    .clear     (grant_c),
    .expired_c (expired_c)
  );

  // Next owner, round-robin pointer and the payload to display after the edge.
  always_comb begin
    state_nxt = state_q;
    rr_b_nxt  = rr_b_q;
    grant_c   = 1'b0;
    disp_nxt  = '{data: IDLE_VALUE, dp: IDLE_DP};

    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt = rr_b_q ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_nxt = OWN_A;
        end else if (req_b) begin
          state_nxt = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          state_nxt = req_b ? OWN_B : IDLE;
        end else if (req_b && expired_c) begin
          state_nxt = OWN_B;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_nxt = req_a ? OWN_A : IDLE;
        end else if (req_a && expired_c) begin
          state_nxt = OWN_A;
        end
      end
      default: state_nxt = IDLE;
    endcase

    grant_c = (state_nxt != IDLE) && (state_nxt != state_q);
    if (grant_c) begin
      rr_b_nxt = (state_nxt == OWN_A);
    end

    case (state_nxt)
      OWN_A:   disp_nxt = '{data: data_a, dp: dp_a};
      OWN_B:   disp_nxt = '{data: data_b, dp: dp_b};
      default: disp_nxt = '{data: IDLE_VALUE, dp: IDLE_DP};
    endcase
  end

  // State and all outputs update together, so grants and digits never skew.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q                          <= IDLE;
      rr_b_q                           <= 1'b0;
      gnt_a                            <= 1'b0;
      gnt_b                            <= 1'b0;
      owner                            <= OWNER_IDLE;
      {digit0, digit1, digit2, digit3} <= IDLE_VALUE;
      decplace                         <= IDLE_DP;
    end else begin
      state_q                          <= state_nxt;
      rr_b_q                           <= rr_b_nxt;
      gnt_a                            <= (state_nxt == OWN_A);
      gnt_b                            <= (state_nxt == OWN_B);
      owner                            <= owner_of(state_nxt);
      {digit0, digit1, digit2, digit3} <= disp_nxt.data;
      decplace                         <= disp_nxt.dp;
    end
  end

  a_gnt_exclusive : assert property (@(posedge clk1) disable iff (!rst_n)
    !(gnt_a && gnt_b));

  a_owner_legal : assert property (@(posedge clk1) disable iff (!rst_n)
    owner != 2'b11);

endmodule

// File: doc/sevenseg_display_arbiter.md
Name: sevenseg_display_arbiter

Overview:
Shares the 4-digit seven-segment display between two independent requesters (A and B) with a req/gnt handshake. Round-robin arbitration with a minimum hold time. Registered digit/decimal-point outputs drive the multiplexed display driver's digit0..digit3 and decplace inputs directly. An idle pattern is shown when no requester owns the display.

Parameters:
HOLD_CYCLES, 50000000, minimum ownership cycles before a waiting requester may preempt; must be >= 1.
IDLE_VALUE, 16'h0000, four hex digits shown when idle; [15:12] is the leftmost digit.
IDLE_DP, 2'b00, decimal-point position shown when idle.

Ports:
clk1  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
req_a  in  1  requester A wants the display; level, held while wanted.
data_a  in  16  A's four hex digits; [15:12] leftmost, [3:0] rightmost.
dp_a  in  2  A's decimal-point position.
gnt_a  out  1  A owns the display.
req_b  in  1  as req_a, for B.
data_b  in  16  as data_a, for B.
dp_b  in  2  as dp_a, for B.
gnt_b  out  1  B owns the display.
digit0  out  4  leftmost digit; equals selected data[15:12].
digit1  out  4  selected data[11:8].
digit2  out  4  selected data[7:4].
digit3  out  4  rightmost digit; selected data[3:0].
decplace  out  2  selected dp.
owner  out  2  2'b00 idle, 2'b01 A, 2'b10 B; never 2'b11.

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt_a = gnt_b = 0; owner = 00; digits = IDLE_VALUE nibbles; decplace = IDLE_DP; rr pointer favours A; hold counter = 0.
- States: IDLE, OWN_A, OWN_B. All outputs are registered. gnt_a/gnt_b are never high together; handover between A and B has no idle gap.
- IDLE:
  - Only one req high: go to its OWN state at the next edge.
  - Both high: the rr pointer picks the winner.
  - Neither high: stay in IDLE and hold the idle pattern.
- Grant edge: at the edge that asserts gnt_x, outputs also load data_x/dp_x. Latency from req rising to gnt and display is 1 cycle.
- OWN_x:
  - Outputs reload data_x/dp_x every cycle; data sampled at cycle t is visible after edge t+1.
  - Hold counter clears on entry to OWN_x and increments each cycle, saturating. expired = (count == HOLD_CYCLES-1).
- Leaving OWN_x, in priority order:
  - req_x low and other req high: go to OWN_other next edge, regardless of expired.
  - req_x low and other req low: go to IDLE next edge; outputs load the idle pattern at that edge.
  - req_x high, other req high, expired: preempt to OWN_other next edge.
  - Otherwise: stay in OWN_x.
- rr pointer: on every grant edge, set to the requester that did not win.
- Requester protocol: after losing gnt while req is still high, the requester keeps req high; it is regranted by the rules above. No ack beyond gnt.
- Reset mid-ownership: gnt and digits return to reset values immediately, without waiting for a clock edge.
- HOLD_CYCLES = 1: a waiting requester preempts after one owned cycle, giving alternation every cycle under constant contention.
- Counter width: $clog2(HOLD_CYCLES+1); the counter never wraps.

Decomposition:
- Package sevenseg_arb_pkg holds:
  - state encoding (IDLE, OWN_A, OWN_B);
  - owner codes (OWNER_IDLE = 2'b00, OWNER_A = 2'b01, OWNER_B = 2'b10).
- Sub-module sevenseg_hold_timer: saturating counter with clear input and expired output, parameterised by HOLD_CYCLES.
- FSM, rr pointer and output mux live in the top module.

Test Plan:
- Reset: rst_n = 0 with IDLE_VALUE = 16'hC0DE, IDLE_DP = 2'b01 -> digit0..3 = C,0,D,E; decplace = 01; gnt_a = gnt_b = 0; owner = 00, all before any clock edge.
- Single owner: req_a = 1, data_a = 16'h1234, dp_a = 2 at cycle 0 -> after edge 1: gnt_a = 1, owner = 01, digits 1,2,3,4, decplace 2. data_a changed to 16'h5678 at cycle 3 -> digits 5,6,7,8 after edge 4.
- Contention with preemption (HOLD_CYCLES = 4): A owns from edge 1; req_b = 1, data_b = 16'hBEEF from cycle 1 with req_a held high -> gnt_a drops and gnt_b rises at edge 5, digits B,E,E,F. With both still requesting, A is regranted at edge 9.
- Early release: A owns, req_b high, req_a drops at cycle 2 (before expiry) -> gnt_b = 1 at edge 3. B then drops with A idle -> owner = 00 and idle pattern at the following edge.
- Simultaneous requests from IDLE: req_a = req_b = 1 at cycle 0 -> A granted after edge 1. Both drop, return to IDLE, then both request again -> B granted.
- Reset mid-operation: rst_n pulsed low while B owns -> gnt_b = 0, owner = 00, idle digits immediately. After release with req_b high -> gnt_b = 1 one edge later.
